// File: rtl/rf_tx_bit_scheduler_if.sv
// rf_tx_bit_scheduler_if
//
// Handshake and RF-control bundle for rf_tx_bit_scheduler.
//   master modport (frame source / bench): drives tx_data, tx_valid, freq_sel_0, freq_sel_1;
//                                          observes tx_ready, f0, f1, baseband pulses, busy, done.
//   slave modport (scheduler): the converse.
interface rf_tx_bit_scheduler_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              freq_sel_0;
    logic              freq_sel_1;
    logic              f0;
    logic              f1;
    logic              baseband_pulse_0;
    logic              baseband_pulse_1;
    logic              busy;
    logic              done;

    modport master (
        output tx_data, tx_valid, freq_sel_0, freq_sel_1,
        input  tx_ready, f0, f1, baseband_pulse_0, baseband_pulse_1, busy, done
    );

    modport slave (
        input  tx_data, tx_valid, freq_sel_0, freq_sel_1,
        output tx_ready, f0, f1, baseband_pulse_0, baseband_pulse_1, busy, done
    );
endinterface

// File: rtl/rf_tx_bit_scheduler.sv
// rf_tx_bit_scheduler
//
// Serializes one DATA_W word per handshake, MSB first. Each bit is a PULSE_CYCLES-long
// enable on baseband_pulse_1 (bit 1) or baseband_pulse_0 (bit 0), followed by GAP_CYCLES
// of silence. f0/f1 are latched on accept and held for the whole frame.
// Optional feature: define RF_TX_PREAMBLE_EN to prepend PREAMBLE_BITS alternating bits
// (1,0,1,0...) before the payload.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - rf_tx_bit_scheduler_if.slave (tx_data/tx_valid/tx_ready handshake, freq_sel_*,
//          f0/f1, baseband_pulse_0/1, busy, done); all outputs registered.
module rf_tx_bit_scheduler #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned PULSE_CYCLES  = 16,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned PREAMBLE_BITS = 4
) (
    input logic                   clk,
    input logic                   rst,
    rf_tx_bit_scheduler_if.slave  bus
);
    localparam int unsigned CYC_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(DATA_W + PREAMBLE_BITS + 1);
`ifdef RF_TX_PREAMBLE_EN
    localparam int unsigned N_BITS  = DATA_W + PREAMBLE_BITS;
    localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'(PREAMBLE_BITS - 1);
`else
    localparam int unsigned N_BITS  = DATA_W;
`endif
    localparam logic [CYC_W-1:0] PULSE_LAST = CYC_W'(PULSE_CYCLES - 1);
    localparam logic [CYC_W-1:0] GAP_LAST   = CYC_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPulse    = 3'd1,
        StGap      = 3'd2,
        StDone     = 3'd3
`ifdef RF_TX_PREAMBLE_EN
        ,
        StPreamble = 3'd4
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_next;
    logic              f0_q, f0_d, f1_q, f1_d;
    logic              pulse0_q, pulse0_d, pulse1_q, pulse1_d;
    logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
`ifdef RF_TX_PREAMBLE_EN
    logic              pre_gap_q, pre_gap_d;  // 0: preamble pulse phase, 1: preamble gap phase
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            f0_q      <= 1'b0;
            f1_q      <= 1'b0;
            pulse0_q  <= 1'b0;
            pulse1_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RF_TX_PREAMBLE_EN
            pre_gap_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            f0_q      <= f0_d;
            f1_q      <= f1_d;
            pulse0_q  <= pulse0_d;
            pulse1_q  <= pulse1_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef RF_TX_PREAMBLE_EN
            pre_gap_q <= pre_gap_d;
`endif
        end
    end

    // Outputs are registered, so every *_d below is the value seen in the next cycle.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q + CYC_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        shift_next = shift_q << 1;
        f0_d       = f0_q;
        f1_d       = f1_q;
        pulse0_d   = pulse0_q;
        pulse1_d   = pulse1_q;
        done_d     = 1'b0;
`ifdef RF_TX_PREAMBLE_EN
        pre_gap_d  = pre_gap_q;
`endif

        case (state_q)
            StIdle: begin
                cyc_d = '0;
                if (bus.tx_valid && ready_q) begin
                    shift_d = bus.tx_data;
                    f0_d    = bus.freq_sel_0;
                    f1_d    = bus.freq_sel_1;
                    bit_d   = '0;
`ifdef RF_TX_PREAMBLE_EN
                    state_d   = StPreamble;
                    pre_gap_d = 1'b0;
                    pulse1_d  = 1'b1;  // preamble starts with a 1
                    pulse0_d  = 1'b0;
`else
                    state_d  = StPulse;
                    pulse1_d = bus.tx_data[DATA_W-1];
                    pulse0_d = ~bus.tx_data[DATA_W-1];
`endif
                end
            end
`ifdef RF_TX_PREAMBLE_EN
            StPreamble: begin
                if (!pre_gap_q) begin
                    if (cyc_q == PULSE_LAST) begin
                        pre_gap_d = 1'b1;
                        cyc_d     = '0;
                        pulse0_d  = 1'b0;
                        pulse1_d  = 1'b0;
                    end
                end else if (cyc_q == GAP_LAST) begin
                    cyc_d     = '0;
                    pre_gap_d = 1'b0;
                    bit_d     = bit_q + BIT_W'(1);
                    if (bit_q == PRE_LAST) begin
                        state_d  = StPulse;
                        pulse1_d = shift_q[DATA_W-1];
                        pulse0_d = ~shift_q[DATA_W-1];
                    end else begin
                        // Next preamble index is bit_q+1; it is a 1 when that index is even.
                        pulse1_d = bit_q[0];
                        pulse0_d = ~bit_q[0];
                    end
                end
            end
`endif
            StPulse: begin
                if (cyc_q == PULSE_LAST) begin
                    state_d  = StGap;
                    cyc_d    = '0;
                    pulse0_d = 1'b0;
                    pulse1_d = 1'b0;
                end
            end
            StGap: begin
                if (cyc_q == GAP_LAST) begin
                    cyc_d   = '0;
                    shift_d = shift_next;
                    if (bit_q == BIT_LAST) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StPulse;
                        bit_d    = bit_q + BIT_W'(1);
                        pulse1_d = shift_next[DATA_W-1];
                        pulse0_d = ~shift_next[DATA_W-1];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                pulse0_d = 1'b0;
                pulse1_d = 1'b0;
            end
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = ~ready_d;
    end

    assign bus.tx_ready         = ready_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.f0               = f0_q;
    assign bus.f1               = f1_q;
    assign bus.baseband_pulse_0 = pulse0_q;
    assign bus.baseband_pulse_1 = pulse1_q;
endmodule

// File: tb/tb_rf_tx_bit_scheduler.sv
module tb_rf_tx_bit_scheduler;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned P      = 4;
    localparam int unsigned G      = 2;
    localparam int unsigned PB     = 4;
`ifdef RF_TX_PREAMBLE_EN
    localparam int unsigned N      = DATA_W + PB;
`else
    localparam int unsigned N      = DATA_W;
`endif
    localparam int unsigned FRAME  = N * (P + G);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_tx_bit_scheduler_if #(.DATA_W(DATA_W)) bus ();

    rf_tx_bit_scheduler #(
        .DATA_W        (DATA_W),
        .PULSE_CYCLES  (P),
        .GAP_CYCLES    (G),
        .PREAMBLE_BITS (PB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    logic done_prev = 1'b0;

    // {pulse_1, pulse_0, done, busy, tx_ready, f0, f1}
    function automatic logic [6:0] obs();
        return {bus.baseband_pulse_1, bus.baseband_pulse_0, bus.done, bus.busy,
                bus.tx_ready, bus.f0, bus.f1};
    endfunction

    function automatic logic exp_bit(input logic [DATA_W-1:0] d, input int b);
        logic [DATA_W-1:0] dv;
        int idx;
        dv = d;
`ifdef RF_TX_PREAMBLE_EN
        if (b < int'(PB)) return (b % 2) == 0;
        idx = DATA_W - 1 - (b - int'(PB));
`else
        idx = DATA_W - 1 - b;
`endif
        return dv[idx];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants: enables mutually exclusive, done one cycle wide.
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (bus.baseband_pulse_0 === 1'b1 && bus.baseband_pulse_1 === 1'b1) begin
                n_fail++;
                $display("FAIL pulse_exclusive t=%0t actual p0=%b p1=%b required not both 1",
                         $time, bus.baseband_pulse_0, bus.baseband_pulse_1);
            end
            n_tests++;
            if (bus.done === 1'b1 && done_prev === 1'b1) begin
                n_fail++;
                $display("FAIL done_width t=%0t actual done high 2 cycles required 1", $time);
            end
            done_prev = bus.done;
        end
    end

    // Accepts one word (DUT must be idle and ready) and checks every cycle through the
    // first ready cycle after done. hold keeps tx_valid high with next_data during the frame.
    task automatic run_frame(input string name, input logic [DATA_W-1:0] data,
                             input logic fs0, input logic fs1, input logic toggle,
                             input logic hold, input logic [DATA_W-1:0] next_data);
        logic [6:0] exp;
        logic e1, e0, d, bz, rd, bv;
        int b, ph;
        n_tests++;
        if (bus.tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_before_accept actual=%b required=1", name, bus.tx_ready);
        end
        bus.tx_data    = data;
        bus.tx_valid   = 1'b1;
        bus.freq_sel_0 = fs0;
        bus.freq_sel_1 = fs1;
        step();
        bus.tx_valid = hold;
        bus.tx_data  = next_data;
        for (int c = 1; c <= int'(FRAME) + 2; c++) begin
            b  = (c - 1) / int'(P + G);
            ph = (c - 1) % int'(P + G);
            e1 = 1'b0; e0 = 1'b0; d = 1'b0; bz = 1'b1; rd = 1'b0;
            if (c <= int'(FRAME)) begin
                bv = exp_bit(data, b);
                if (ph < int'(P)) begin
                    e1 = bv;
                    e0 = ~bv;
                end
            end else if (c == int'(FRAME) + 1) begin
                d = 1'b1;
            end else begin
                bz = 1'b0;
                rd = 1'b1;
            end
            exp = {e1, e0, d, bz, rd, fs0, fs1};
            n_tests++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL %s cycle t0+%0d actual {p1,p0,done,busy,rdy,f0,f1}=%b required=%b",
                         name, c, obs(), exp);
            end
            if (toggle) begin
                bus.freq_sel_0 = ~bus.freq_sel_0;
                bus.freq_sel_1 = ~bus.freq_sel_1;
            end
            if (c < int'(FRAME) + 2) step();
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = '0;
        bus.freq_sel_0 = 1'b0;
        bus.freq_sel_1 = 1'b0;
        step();
        step();
        n_tests++;
        if (obs() !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_values actual=%b required=%b", obs(), 7'b0);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (obs() !== 7'b0000100) begin
            n_fail++;
            $display("FAIL reset_ready_rise actual=%b required=%b", obs(), 7'b0000100);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        run_frame("basic_a5", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        run_frame("basic_ff", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        run_frame("basic_01", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_freq_hold();
        run_frame("freq_hold", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
        run_frame("b2b_second", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid();
        bus.tx_data    = 8'hA5;
        bus.tx_valid   = 1'b1;
        bus.freq_sel_0 = 1'b1;
        bus.freq_sel_1 = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        for (int c = 1; c < 20; c++) step();
        rst = 1'b1;
        step();
        n_tests++;
        if (obs() !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs actual=%b required=%b", obs(), 7'b0);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (obs() !== 7'b0000100) begin
            n_fail++;
            $display("FAIL mid_reset_ready actual=%b required=%b", obs(), 7'b0000100);
        end
        for (int c = 0; c < 40; c++) begin
            n_tests++;
            if (bus.done !== 1'b0 || bus.baseband_pulse_0 !== 1'b0 ||
                bus.baseband_pulse_1 !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_abandoned cycle %0d actual {p1,p0,done}=%b%b%b required 000",
                         c, bus.baseband_pulse_1, bus.baseband_pulse_0, bus.done);
            end
            step();
        end
        run_frame("after_reset", 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

`ifdef RF_TX_PREAMBLE_EN
    task automatic test_preamble();
        run_frame("preamble_00", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_freq_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef RF_TX_PREAMBLE_EN
        test_preamble();
`endif
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_tx_bit_scheduler.md
# rf_tx_bit_scheduler

Frame-level controller for the RF pulse generator pair (bit-'0' and bit-'1' generators). Accepts one data word per valid/ready handshake and serializes it MSB-first. For each bit it drives a fixed-length baseband pulse on exactly one of the two generator enables, then a guard gap. It also holds the generators' frequency-control inputs stable for the whole frame.

## Interface
- `DATA_W`, 8, bits per frame; ≥1.
- `PULSE_CYCLES`, 16, clk cycles a baseband pulse is held high per bit; ≥1.
- `GAP_CYCLES`, 8, clk cycles of silence after each pulse; ≥1.
- `PREAMBLE_BITS`, 4, preamble length in bits; used only when `RF_TX_PREAMBLE_EN` is defined; ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  DATA_W  frame payload; sampled on accept.
- `tx_valid`  in  1  payload valid.
- `tx_ready`  out  1  scheduler can accept; high only in IDLE.
- `freq_sel_0`  in  1  frequency control for the '0' generator; sampled on accept.
- `freq_sel_1`  in  1  frequency control for the '1' generator; sampled on accept.
- `f0`  out  1  registered frequency control to the '0' generator.
- `f1`  out  1  registered frequency control to the '1' generator.
- `baseband_pulse_0`  out  1  baseband enable for the '0' generator.
- `baseband_pulse_1`  out  1  baseband enable for the '1' generator.
- `busy`  out  1  high from the cycle after accept through the DONE cycle.
- `done`  out  1  one-cycle completion strobe.

## Operation
- All outputs are registered.
- Reset values: `tx_ready`=0, `f0`=0, `f1`=0, `baseband_pulse_0`=0, `baseband_pulse_1`=0, `busy`=0, `done`=0. State is IDLE; `tx_ready` rises on the first cycle after `rst` deasserts.
- States: IDLE, PREAMBLE (macro only), PULSE, GAP, DONE.
- **IDLE**:
  - `tx_ready`=1.
  - Accept occurs on an edge where `tx_valid`&&`tx_ready`. On accept: latch `tx_data` into the shift register, latch `f0`←`freq_sel_0` and `f1`←`freq_sel_1`, clear the bit counter.
  - Next state is PREAMBLE if enabled, else PULSE.
- **PULSE**:
  - Current bit = shift register MSB.
  - Bit=1 drives `baseband_pulse_1`=1 and `baseband_pulse_0`=0; bit=0 the converse. The two enables are never both high.
  - Lasts exactly `PULSE_CYCLES` cycles, then → GAP.
- **GAP**:
  - Both enables 0 for exactly `GAP_CYCLES` cycles.
  - The shift register shifts left at the end of the gap.
  - → PULSE if bits remain, else → DONE.
- **DONE**: `done`=1 and `busy`=1 for one cycle, then → IDLE.
- `f0`/`f1` hold their latched values until the next accept. They do not change mid-frame even if `freq_sel_*` toggles.
- `tx_valid` while not in IDLE is ignored; no data is lost, because `tx_ready`=0.
- `rst` mid-frame: on the next edge all outputs take reset values, state is IDLE, and the frame is abandoned (no `done`).
- Counter widths: `$clog2` of max(`PULSE_CYCLES`, `GAP_CYCLES`)+1 for the cycle counter; `$clog2`(`DATA_W`+`PREAMBLE_BITS`+1) for the bit counter. No wrap occurs within legal parameters.

## Timing
- Accept on edge t0:
  - First pulse is high in cycles t0+1 … t0+PULSE_CYCLES.
  - The first gap follows immediately.
- Bit period = `PULSE_CYCLES`+`GAP_CYCLES` cycles. Frame = N bit periods, where N = `DATA_W` (+`PREAMBLE_BITS` with macro).
- `done` is high in cycle t0+N·(PULSE_CYCLES+GAP_CYCLES)+1.
- `tx_ready` is high from the following cycle; the earliest next accept is on that edge.
- `busy` = !`tx_ready` outside reset.

## Configuration
- `RF_TX_PREAMBLE_EN` defined:
  - PREAMBLE state is compiled in.
  - Before the payload, `PREAMBLE_BITS` bits alternating 1,0,1,0… (starting with 1) are sent.
  - Each preamble bit uses the same pulse/gap timing and the same latched `f0`/`f1`.
  - PREAMBLE → PULSE after the last preamble gap.
- Not defined:
  - The PREAMBLE state and its counter logic are absent.
  - `PREAMBLE_BITS` is unused.
  - The frame starts with the payload MSB.

## Test plan
- Parameters `DATA_W`=8, `PULSE_CYCLES`=4, `GAP_CYCLES`=2, no macro.
  - Stimulus: accept `tx_data`=8'hA5 at t0.
  - Required response: enable pattern 1,0,1,0,0,1,0,1 on `baseband_pulse_1`/`_0`; each pulse 4 cycles high, 2 low; `done` at t0+49; `tx_ready` at t0+50.
- Same setup with `freq_sel_0`=1, `freq_sel_1`=0 at accept; toggle both every cycle during the frame.
  - Required response: `f0`=1 and `f1`=0 throughout the frame.
- Hold `tx_valid`=1 with new data during the frame.
  - Required response: second word accepted only on the edge after `done`; its first pulse starts the next cycle.
- Assert `rst` for 1 cycle at t0+20 mid-frame.
  - Required response: all outputs 0 the next cycle; no `done`; `tx_ready`=1 one cycle after `rst` falls.
- With `RF_TX_PREAMBLE_EN`, `PREAMBLE_BITS`=4, accept 8'h00.
  - Required response: `baseband_pulse_1` fires for preamble bits 1 and 3, `baseband_pulse_0` for preamble bits 2 and 4 and all 8 data bits; `done` at t0+73.
- Every scenario, checked each cycle:
  - `baseband_pulse_0`&&`baseband_pulse_1` never true.
  - `done` only ever one cycle wide.
